key_sw_dev: RTL

Memory-mapped responder for the KEY and SW inputs of the multi-cycle processor. It answers the processor's load/store bus at the KEY and SW addresses: it synchronizes and debounces the raw inputs, and latches a change event into a Ready flag that the program polls. An interrupt request is also available. It replaces the direct combinational KEY/SW taps in the memory-read multiplexer.

---
 rtl/kswdev_pkg.sv | 50 +++++
 rtl/debounce_group.sv | 61 ++++++
 rtl/key_sw_dev.sv | 86 ++++++++
 3 files changed

// File: rtl/kswdev_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | kswdev_pkg : shared offsets, CTRL bit layout and helpers for key_sw_dev     |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
package kswdev_pkg;

  localparam logic [31:0] OFF_DATA = 32'h0000_0000;
  localparam logic [31:0] OFF_CTRL = 32'h0000_0004;

  localparam int CTRL_READY = 0;
  localparam int CTRL_OVR   = 2;
  localparam int CTRL_IE    = 8;

  // Must track the processor's ADDRKEY/ADDRSW constants.
  localparam logic [31:0] DEF_ADDRKEY = 32'hFFFF_F080;
  localparam logic [31:0] DEF_ADDRSW  = 32'hFFFF_F090;

  typedef struct packed {
    logic ie;
    logic ovr;
    logic ready;
  } ctrl_t;

  function automatic logic [31:0] ctrl_word(input ctrl_t c);
    logic [31:0] w;
    w             = '0;
    w[CTRL_READY] = c.ready;
    w[CTRL_OVR]   = c.ovr;
    w[CTRL_IE]    = c.ie;
    return w;
  endfunction

  // Event wins over a Ready-clearing load; a colliding load also suppresses Overrun.
  function automatic ctrl_t ctrl_next(input ctrl_t c, input logic evt, input logic data_ld,
                                      input logic ctrl_st, input logic st_ovr, input logic st_ie);
    ctrl_t n;
    n = c;
    if (ctrl_st) begin
      n.ie = st_ie;
      if (!st_ovr) n.ovr = 1'b0;
    end
    if (evt && c.ready && !data_ld) n.ovr = 1'b1;
    if (evt)          n.ready = 1'b1;
    else if (data_ld) n.ready = 1'b0;
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_group.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | debounce_group : 2-flop synchronizer plus stable-count debouncer            |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module debounce_group #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] deb_o,
  output logic             event_o
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1_q, s2_q, cand_q, cand_d, deb_q, deb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             event_d;

  always_comb begin
    cand_d  = cand_q;
    cnt_d   = '0;
    deb_d   = deb_q;
    event_d = 1'b0;
    if (s2_q != cand_q) begin
      cand_d = s2_q;
    end else if (cand_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d   = cand_q;
        event_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= '0;
      s2_q   <= '0;
      cand_q <= '0;
      cnt_q  <= '0;
      deb_q  <= '0;
    end else begin
      s1_q   <= raw_i;
      s2_q   <= s1_q;
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
    end
  end

  assign deb_o   = deb_q;
  assign event_o = event_d;

endmodule
`default_nettype wire

// File: rtl/key_sw_dev.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | key_sw_dev : memory-mapped KEY/SW responder with Ready/Overrun/IE and irq   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module key_sw_dev
  import kswdev_pkg::*;
#(
  parameter int               DBITS           = 32,
  parameter logic [DBITS-1:0] ADDRKEY         = DBITS'(DEF_ADDRKEY),
  parameter logic [DBITS-1:0] ADDRSW          = DBITS'(DEF_ADDRSW),
  parameter int               DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             RESET_N,
  input  logic [DBITS-1:0] addr,
  input  logic [DBITS-1:0] wrdata,
  input  logic             we,
  input  logic             re,
  output logic             sel,
  output logic [DBITS-1:0] rddata,
  output logic             irq,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW
);

  logic       hit_kdata, hit_kctrl, hit_sdata, hit_sctrl;
  logic [3:0] key_deb;
  logic [9:0] sw_deb;
  logic       key_evt, sw_evt;
  ctrl_t      kctrl_q, kctrl_d, sctrl_q, sctrl_d;

  assign hit_kdata = (addr == ADDRKEY + DBITS'(OFF_DATA));
  assign hit_kctrl = (addr == ADDRKEY + DBITS'(OFF_CTRL));
  assign hit_sdata = (addr == ADDRSW  + DBITS'(OFF_DATA));
  assign hit_sctrl = (addr == ADDRSW  + DBITS'(OFF_CTRL));
  assign sel       = hit_kdata | hit_kctrl | hit_sdata | hit_sctrl;

  // KEY is active-low at the pins; debounce the pressed=1 view.
  debounce_group #(.WIDTH(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_deb (
    .clk     (clk),
    .rst_ni  (RESET_N),
    .raw_i   (~KEY),
    .deb_o   (key_deb),
    .event_o (key_evt)
  );

  debounce_group #(.WIDTH(10), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_deb (
    .clk     (clk),
    .rst_ni  (RESET_N),
    .raw_i   (SW),
    .deb_o   (sw_deb),
    .event_o (sw_evt)
  );

  always_comb begin
    kctrl_d = ctrl_next(kctrl_q, key_evt, re & hit_kdata, we & hit_kctrl,
                        wrdata[CTRL_OVR], wrdata[CTRL_IE]);
    sctrl_d = ctrl_next(sctrl_q, sw_evt, re & hit_sdata, we & hit_sctrl,
                        wrdata[CTRL_OVR], wrdata[CTRL_IE]);
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      kctrl_q <= '0;
      sctrl_q <= '0;
    end else begin
      kctrl_q <= kctrl_d;
      sctrl_q <= sctrl_d;
    end
  end

  always_comb begin
    rddata = '0;
    if (re) begin
      if (hit_kdata)      rddata = DBITS'(key_deb);
      else if (hit_kctrl) rddata = DBITS'(ctrl_word(kctrl_q));
      else if (hit_sdata) rddata = DBITS'(sw_deb);
      else if (hit_sctrl) rddata = DBITS'(ctrl_word(sctrl_q));
    end
  end

  assign irq = (kctrl_q.ready & kctrl_q.ie) | (sctrl_q.ready & sctrl_q.ie);

endmodule
`default_nettype wire
